// File: rtl/trafficlight_timed_controller.sv
// Highway/farm-road light controller with per-phase dwell timer, min highway green and all-red gaps.
// Define TRAFFICLIGHT_TIMEOUT_EN to enable the ROAD_MAX_GREEN timeout and its `timeout` pulse.
module trafficlight_timed_controller #(
   parameter int CNT_W          = 8,
   parameter int HWY_MIN_GREEN  = 8,
   parameter int YELLOW_CYC     = 3,
   parameter int ALLRED_CYC     = 2,
   parameter int ROAD_MAX_GREEN = 10
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       x,
   output logic [1:0] hwy,
   output logic [1:0] road,
   output logic [2:0] state,
   output logic       timeout
);

   localparam logic [2:0] S_HWY_GREEN   = 3'd0;
   localparam logic [2:0] S_HWY_YELLOW  = 3'd1;
   localparam logic [2:0] S_ALLRED_H2R  = 3'd2;
   localparam logic [2:0] S_ROAD_GREEN  = 3'd3;
   localparam logic [2:0] S_ROAD_YELLOW = 3'd4;
   localparam logic [2:0] S_ALLRED_R2H  = 3'd5;

   localparam logic [1:0] LAMP_RED    = 2'b00;
   localparam logic [1:0] LAMP_GREEN  = 2'b01;
   localparam logic [1:0] LAMP_YELLOW = 2'b10;

   // Exit thresholds are "last held timer value", i.e. dwell minus one.
   localparam logic [CNT_W-1:0] HMG_LAST = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);
`ifdef TRAFFICLIGHT_TIMEOUT_EN
   localparam logic [CNT_W-1:0] RMG_LAST = CNT_W'(ROAD_MAX_GREEN - 1);
`endif

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             timeout_d;

   always_comb begin
      state_d   = state_q;
      timeout_d = 1'b0;
      case (state_q)
         S_HWY_GREEN:   if (x && (timer_q >= HMG_LAST)) state_d = S_HWY_YELLOW;
         S_HWY_YELLOW:  if (timer_q == YEL_LAST)        state_d = S_ALLRED_H2R;
         S_ALLRED_H2R:  if (timer_q == AR_LAST)         state_d = S_ROAD_GREEN;
         S_ROAD_GREEN: begin
            // A car leaving wins over a coincident max-timer expiry.
            if (!x) begin
               state_d = S_ROAD_YELLOW;
            end
`ifdef TRAFFICLIGHT_TIMEOUT_EN
            else if (timer_q == RMG_LAST) begin
               state_d   = S_ROAD_YELLOW;
               timeout_d = 1'b1;
            end
`endif
         end
         S_ROAD_YELLOW: if (timer_q == YEL_LAST)        state_d = S_ALLRED_R2H;
         S_ALLRED_R2H:  if (timer_q == AR_LAST)         state_d = S_HWY_GREEN;
         default:       state_d = S_HWY_GREEN;
      endcase
   end

   always_comb begin
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == {CNT_W{1'b1}}) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_HWY_GREEN;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

`ifdef TRAFFICLIGHT_TIMEOUT_EN
   logic timeout_q;

   always_ff @(posedge clock) begin
      if (clear) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_timeout_d;
   assign unused_timeout_d = timeout_d;
   assign timeout          = 1'b0;
`endif

   always_comb begin
      hwy  = LAMP_RED;
      road = LAMP_RED;
      case (state_q)
         S_HWY_GREEN:   hwy  = LAMP_GREEN;
         S_HWY_YELLOW:  hwy  = LAMP_YELLOW;
         S_ROAD_GREEN:  road = LAMP_GREEN;
         S_ROAD_YELLOW: road = LAMP_YELLOW;
         default: begin
            hwy  = LAMP_RED;
            road = LAMP_RED;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_trafficlight_timed_controller.sv
// Bench for trafficlight_timed_controller: directed scenarios plus random car traffic,
// checked every cycle against a phase/dwell model of the light sequence.
module tb_trafficlight_timed_controller;

   localparam int HMG = 8;
   localparam int YEL = 3;
   localparam int AR  = 2;
   localparam int RMG = 10;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       x     = 1'b0;
   logic [1:0] hwy;
   logic [1:0] road;
   logic [2:0] state;
   logic       timeout;

   int n_cmp = 0;
   int n_bad = 0;

   trafficlight_timed_controller dut (
      .clock   (clock),
      .clear   (clear),
      .x       (x),
      .hwy     (hwy),
      .road    (road),
      .state   (state),
      .timeout (timeout)
   );

   always #5 clock = ~clock;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endfunction

   // Model: phase index 0..5 walked in order, m_cnt = cycles spent in phase including the current one.
   int m_phase = 0;
   int m_cnt   = 1;
   bit m_to    = 1'b0;
   bit m_valid = 1'b0;
   int dwell_fixed[6] = '{0, YEL, AR, 0, YEL, AR};
   int hwy_tab[6]     = '{1, 2, 0, 0, 0, 0};
   int road_tab[6]    = '{0, 0, 0, 1, 2, 0};

   always @(posedge clock) begin
      bit leave;
      bit tmo;
      leave = 1'b0;
      tmo   = 1'b0;
      if (clear) begin
         m_phase = 0;
         m_cnt   = 1;
         m_to    = 1'b0;
         m_valid = 1'b1;
      end else begin
         case (m_phase)
            0: leave = x && (m_cnt >= HMG);
            3: begin
               leave = !x;
`ifdef TRAFFICLIGHT_TIMEOUT_EN
               if (x && m_cnt == RMG) begin
                  leave = 1'b1;
                  tmo   = 1'b1;
               end
`endif
            end
            default: leave = (m_cnt == dwell_fixed[m_phase]);
         endcase
         m_to = tmo;
         if (leave) begin
            m_phase = (m_phase + 1) % 6;
            m_cnt   = 1;
         end else begin
            m_cnt++;
         end
      end
   end

   always @(posedge clock) begin
      #2;
      if (m_valid) begin
         chk("model_state",   int'(state),   m_phase);
         chk("model_hwy",     int'(hwy),     hwy_tab[m_phase]);
         chk("model_road",    int'(road),    road_tab[m_phase]);
         chk("model_timeout", int'(timeout), int'(m_to));
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_state(input int s, input int limit);
      int n;
      n = 0;
      while (int'(state) != s && n < limit) begin
         tick();
         n++;
      end
      chk("wait_state", int'(state), s);
   endtask

   function automatic int tmo_seq(input int j);
      if (j < 8)  return 0;
      if (j < 11) return 1;
      if (j < 13) return 2;
      if (j < 23) return 3;
      if (j < 26) return 4;
      if (j < 28) return 5;
      if (j < 36) return 0;
      return 1;
   endfunction

   initial begin
      int exp_a[14];
      int exp_b[6];
      exp_a = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
      exp_b = '{4, 4, 4, 5, 5, 0};

      // Reset and idle highway green
      clear = 1'b1;
      x     = 1'b0;
      tick();
      tick();
      chk("rst_state", int'(state), 0);
      chk("rst_hwy", int'(hwy), 1);
      chk("rst_road", int'(road), 0);
      chk("rst_timeout", int'(timeout), 0);
      clear = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("idle_state", int'(state), 0);
      end

      // Full crossover with x=1 from the first cycle after release
      clear = 1'b1;
      tick();
      clear = 1'b0;
      x     = 1'b1;
      chk("xing_state", int'(state), exp_a[0]);
      for (int i = 1; i < 14; i++) begin
         tick();
         chk("xing_state", int'(state), exp_a[i]);
         if (i == 8) chk("xing_hwy_yellow", int'(hwy), 2);
         if (i == 11) begin
            chk("xing_allred_hwy", int'(hwy), 0);
            chk("xing_allred_road", int'(road), 0);
         end
      end
      chk("xing_road_green", int'(road), 1);

      // Car leaves after 4 cycles of road green
      repeat (3) tick();
      x = 1'b0;
      tick();
      chk("leave_state", int'(state), exp_b[0]);
      chk("leave_timeout", int'(timeout), 0);
      for (int i = 1; i < 6; i++) begin
         tick();
         chk("leave_state", int'(state), exp_b[i]);
      end
      chk("leave_hwy_green", int'(hwy), 1);

      x = 1'b1;
`ifdef TRAFFICLIGHT_TIMEOUT_EN
      // Road green times out, then highway green serves its full minimum
      for (int j = 1; j <= 36; j++) begin
         tick();
         chk("tmo_state", int'(state), tmo_seq(j));
         if (j == 23) chk("tmo_pulse", int'(timeout), 1);
         if (j == 24) chk("tmo_pulse_end", int'(timeout), 0);
      end
`else
      // No timeout: road green holds as long as the car stays
      for (int j = 1; j <= 62; j++) begin
         tick();
         chk("hold_state", int'(state), (j < 13) ? tmo_seq(j) : 3);
         chk("hold_timeout", int'(timeout), 0);
      end
`endif

      // Mid-operation reset during road yellow
      wait_state(3, 200);
      x = 1'b0;
      wait_state(4, 20);
      clear = 1'b1;
      tick();
      chk("midrst_state", int'(state), 0);
      chk("midrst_hwy", int'(hwy), 1);
      chk("midrst_road", int'(road), 0);
      clear = 1'b0;
      x     = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("midrst_seq", int'(state), (k < 8) ? 0 : 1);
      end

      // Random traffic with occasional resets
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 5) == 0) x = ~x;
         clear = ($urandom_range(0, 299) == 0);
         tick();
      end
      clear = 1'b0;
      tick();
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
